// File: rtl/regfile_mp.sv
// Parametrised integer register file: NRD combinational read ports, one write port,
// per-register busy scoreboard, post-reset clear sweep. Optional bypass: REGFILE_MP_BYPASS_EN.
module regfile_mp #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready_o,
  input  logic [NRD*AW-1:0]   read_sel_i,
  output logic [NRD*XLEN-1:0] read_data_o,
  output logic [NRD-1:0]      read_busy_o,
  input  logic                write_en_i,
  input  logic [AW-1:0]       write_sel_i,
  input  logic [XLEN-1:0]     write_data_i,
  input  logic                alloc_en_i,
  input  logic [AW-1:0]       alloc_sel_i
);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e            state_q;
  logic [AW-1:0]     clr_idx_q;
  logic              ready_q;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [XLEN-1:0]   regs_q [NREGS];

  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [XLEN-1:0]   wr_data;
  logic              wr_hit;

  assign ready_o = ready_q;
  assign wr_hit  = write_en_i && (write_sel_i != '0);

  // Alloc is applied after the write-clear so a same-edge alloc leaves the entry busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_hit) busy_d[write_sel_i] = 1'b0;
    if (alloc_en_i && (alloc_sel_i != '0)) busy_d[alloc_sel_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StClear;
      clr_idx_q <= AW'(1);
      ready_q   <= 1'b0;
      busy_q    <= '0;
    end else begin
      unique case (state_q)
        StClear: begin
          clr_idx_q <= clr_idx_q + AW'(1);
          if (clr_idx_q == AW'(NREGS - 1)) begin
            state_q <= StReady;
            ready_q <= 1'b1;
          end
        end
        StReady: busy_q <= busy_d;
        default: begin
          state_q <= StClear;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // The sweep owns the single array write port while clearing.
  always_comb begin
    if (state_q == StClear) begin
      wr_en   = 1'b1;
      wr_idx  = clr_idx_q;
      wr_data = '0;
    end else begin
      wr_en   = wr_hit;
      wr_idx  = write_sel_i;
      wr_data = write_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) regs_q[wr_idx] <= wr_data;
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   sel;
    logic [XLEN-1:0] rdata;
    logic            rbusy;

    assign sel = read_sel_i[g*AW +: AW];

    always_comb begin
      rdata = '0;
      rbusy = 1'b0;
      if ((state_q == StReady) && (sel != '0)) begin
        rdata = regs_q[sel];
        rbusy = busy_q[sel];
`ifdef REGFILE_MP_BYPASS_EN
        if (wr_hit && (sel == write_sel_i)) begin
          rdata = write_data_i;
          rbusy = alloc_en_i && (alloc_sel_i == write_sel_i);
        end
`endif
      end
    end

    assign read_data_o[g*XLEN +: XLEN] = rdata;
    assign read_busy_o[g]              = rbusy;
  end

endmodule
